// File: rtl/pdm_mic_capture.sv
// PDM mic front end: mic clock, 2-flop capture, 3rd-order CIC (20-bit) to saturated 16-bit PCM; strobe 4 cycles after the last tick of a window.
// No backpressure: fifo_full_i in the strobe cycle drops the sample and counts it. `define PDM_DCBLOCK_EN adds a DC-block stage (+1 cycle).
module pdm_mic_capture #(
    parameter int CLK_DIV = 16,
    parameter int DECIM   = 64
) (
    input  logic        clk_osc,
    input  logic        reset_n_HFCLKOUT,
    input  logic        enable_i,
    input  logic        mic_pdm_data_i,
    output logic        mic_clk_o,
    output logic [15:0] pcm_data_o,
    output logic        pcm_vld_o,
    input  logic        fifo_full_i,
    output logic        overflow_o,
    output logic [15:0] drop_cnt_o
);
    localparam int DIVW  = $clog2(CLK_DIV);
    localparam int DECW  = $clog2(DECIM);
    localparam int SHIFT = 3 * DECW - 15;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
    localparam logic [DIVW-1:0] DIV_HALF = DIVW'(CLK_DIV / 2);
    localparam logic [DECW-1:0] DEC_LAST = DECW'(DECIM - 1);

    typedef struct packed {
        logic [DIVW-1:0]    div;
        logic               mic_clk;
        logic [1:0]         sync;
        logic [DECW-1:0]    dec;
        logic signed [19:0] i1;
        logic signed [19:0] i2;
        logic signed [19:0] i3;
        logic signed [19:0] i3_dly;
        logic signed [19:0] c1;
        logic signed [19:0] c1_dly;
        logic signed [19:0] c2;
        logic signed [19:0] c2_dly;
        logic [3:0]         dv;
        logic [1:0]         warm;
        logic [15:0]        pcm;
        logic               vld;
        logic               ovf;
        logic [15:0]        drop_cnt;
`ifdef PDM_DCBLOCK_EN
        logic signed [15:0] hp_x;
        logic signed [15:0] hp_xprev;
        logic signed [23:0] hp_y;
        logic               hp_go;
`endif
    } state_t;

    function automatic logic signed [15:0] sat16(input logic signed [23:0] v);
        if (v > 24'sd32767)       return 16'sh7fff;
        else if (v < -24'sd32768) return 16'sh8000;
        else                      return v[15:0];
    endfunction

    state_t             st_q, st_d;
    logic               tick, dec_tick, drop;
    logic signed [19:0] x, i1_n, i2_n, i3_n, c3;
    logic signed [23:0] scaled;
    logic signed [15:0] sat_v;
`ifdef PDM_DCBLOCK_EN
    logic signed [23:0] hp_y;
`endif

    // Negative shift only arises for small DECIM, where the comb output needs scaling up.
    generate
        if (SHIFT >= 0) begin : g_shr
            assign scaled = $signed({{4{c3[19]}}, c3}) >>> SHIFT;
        end else begin : g_shl
            assign scaled = $signed({{4{c3[19]}}, c3}) <<< (-SHIFT);
        end
    endgenerate

    always_comb begin
        tick     = (st_q.div == DIV_LAST);
        dec_tick = tick && (st_q.dec == DEC_LAST);
        x        = st_q.sync[1] ? 20'sd1 : -20'sd1;
        i1_n     = st_q.i1 + x;
        i2_n     = st_q.i2 + i1_n;
        i3_n     = st_q.i3 + i2_n;
        c3       = st_q.c2 - st_q.c2_dly;
        sat_v    = sat16(scaled);
        drop     = st_q.vld && enable_i && fifo_full_i;
`ifdef PDM_DCBLOCK_EN
        hp_y     = 24'($signed(st_q.hp_x)) - 24'($signed(st_q.hp_xprev))
                 + $signed(st_q.hp_y) - ($signed(st_q.hp_y) >>> 8);
`endif

        st_d         = st_q;
        st_d.div     = tick ? '0 : st_q.div + 1'b1;
        st_d.mic_clk = (st_d.div < DIV_HALF);
        st_d.sync    = {st_q.sync[0], mic_pdm_data_i};
        st_d.vld     = 1'b0;
        st_d.dv      = {st_q.dv[2:0], dec_tick};
        if (tick) begin
            st_d.i1  = i1_n;
            st_d.i2  = i2_n;
            st_d.i3  = i3_n;
            st_d.dec = st_q.dec + 1'b1;
        end
        if (st_q.dv[0]) begin
            st_d.c1     = st_q.i3 - st_q.i3_dly;
            st_d.i3_dly = st_q.i3;
        end
        if (st_q.dv[1]) begin
            st_d.c2     = st_q.c1 - st_q.c1_dly;
            st_d.c1_dly = st_q.c1;
        end
`ifdef PDM_DCBLOCK_EN
        if (st_q.dv[2]) begin
            st_d.c2_dly = st_q.c2;
            st_d.hp_x   = sat_v;
            st_d.hp_go  = (st_q.warm == 2'd3);
            if (st_q.warm != 2'd3) st_d.warm = st_q.warm + 2'd1;
        end
        if (st_q.dv[3]) begin
            st_d.hp_xprev = st_q.hp_x;
            st_d.hp_y     = hp_y;
            if (st_q.hp_go) begin
                st_d.pcm = sat16(hp_y);
                st_d.vld = 1'b1;
            end
        end
`else
        if (st_q.dv[2]) begin
            st_d.c2_dly = st_q.c2;
            if (st_q.warm == 2'd3) begin
                st_d.pcm = sat_v;
                st_d.vld = 1'b1;
            end else begin
                st_d.warm = st_q.warm + 2'd1;
            end
        end
`endif
        if (drop) begin
            st_d.ovf = 1'b1;
            if (st_q.drop_cnt != 16'hffff) st_d.drop_cnt = st_q.drop_cnt + 16'd1;
        end
        if (!enable_i) st_d = '0;
    end

    always_ff @(posedge clk_osc or negedge reset_n_HFCLKOUT) begin
        if (!reset_n_HFCLKOUT) st_q <= '0;
        else                   st_q <= st_d;
    end

    // fifo_full_i and enable_i gate the strobe in the strobe cycle itself.
    assign mic_clk_o  = st_q.mic_clk;
    assign pcm_data_o = st_q.pcm;
    assign pcm_vld_o  = st_q.vld && enable_i && !fifo_full_i;
    assign overflow_o = st_q.ovf;
    assign drop_cnt_o = st_q.drop_cnt;
endmodule

// File: doc/pdm_mic_capture.md
# pdm_mic_capture

Audio front end for the SX3 bridge: drives the PDM microphone clock (`mic_clk_o`), samples `mic_pdm_data_i`, and decimates the 1-bit stream with a 3rd-order CIC filter into 16-bit signed PCM. Samples go to the audio FIFO that feeds the GPIF audio path (`aud_fifo_*`). The block runs entirely on the internal oscillator domain, upstream of the audio FIFO write port.

## Interface
Parameters:
- `CLK_DIV`, 16: clk_osc cycles per mic clock period; even, ≥4 (48 MHz → 3 MHz).
- `DECIM`, 64: CIC decimation ratio; power of 2, 16..64 (3 MHz → 46.875 kHz).

Ports:
- `clk_osc`  in  1  system clock, 48 MHz internal oscillator.
- `reset_n_HFCLKOUT`  in  1  asynchronous, active-low reset.
- `enable_i`  in  1  audio enable (aud_app_en), synchronous to clk_osc.
- `mic_pdm_data_i`  in  1  PDM data from microphone.
- `mic_clk_o`  out  1  PDM clock to microphone.
- `pcm_data_o`  out  16  signed PCM sample.
- `pcm_vld_o`  out  1  one-cycle write strobe to the audio FIFO.
- `fifo_full_i`  in  1  audio FIFO full.
- `overflow_o`  out  1  sticky: a sample was dropped.
- `drop_cnt_o`  out  16  saturating count of dropped samples.

## Operation
- Reset: all outputs 0; all counters, integrators, combs and flags cleared.
- `enable_i` low:
  - Synchronous clear of the same state as reset.
  - `mic_clk_o` held 0.
  - `overflow_o` and `drop_cnt_o` cleared.
- Clock divider:
  - `div_cnt` runs 0..CLK_DIV-1 and wraps.
  - `mic_clk_o` is registered: 1 while `div_cnt < CLK_DIV/2`, otherwise 0.
- Input capture:
  - `mic_pdm_data_i` passes through a 2-flop synchronizer.
  - A sample tick occurs on the cycle where `div_cnt == CLK_DIV-1`, the end of the low phase.
  - On the tick, the synchronized bit maps to x = +1 (bit 1) or −1 (bit 0).
- CIC:
  - Arithmetic is 20-bit two's complement; wrap-around is permitted. CIC modular arithmetic guarantees a correct result for |output| ≤ DECIM³.
  - Three cascaded integrators update on each tick.
  - `dec_cnt` counts ticks 0..DECIM-1. The tick where it wraps from DECIM-1 is the decimation tick T.
  - Three differential comb stages (delay 1) run pipelined at T+1, T+2, T+3.
- Scaling:
  - The comb output is arithmetic-shifted right by 3·log2(DECIM) − 15, which is 3 for DECIM=64.
  - The result saturates to [−32768, 32767].
  - The value is registered into `pcm_data_o` at T+4.
- Warm-up: the first 3 decimated outputs after reset or enable rising are computed but never strobed.
- Write handshake:
  - At T+4, `pcm_vld_o` = 1 for one cycle when `fifo_full_i` == 0.
  - If `fifo_full_i` == 1 that cycle, the sample is dropped: `pcm_vld_o` stays 0, `overflow_o` sets, and `drop_cnt_o` increments, saturating at 0xFFFF.
  - `pcm_data_o` holds its value between strobes.

## Timing
- Mic clock: 50% duty. The rising edge follows the sample tick by 1 cycle.
- Latency from the tick that captures the last bit of a decimation window to `pcm_vld_o` is 4 clk_osc cycles; 5 with `PDM_DCBLOCK_EN`.
- Output cadence: one strobe every CLK_DIV·DECIM = 1024 clk_osc cycles.
- Reset asserted mid-sample: immediate asynchronous clear. No partial sample is ever strobed.
- `enable_i` falling in the cycle a strobe would occur: the strobe is suppressed and no drop is counted.
- `fifo_full_i` is sampled only in the strobe cycle; it is ignored at all other times.

## Configuration
- `PDM_DCBLOCK_EN` defined:
  - Adds a one-pole DC-blocking high-pass after saturation: y[n] = x[n] − x[n−1] + y[n−1] − (y[n−1] >>> 8).
  - 24-bit signed internal state; the output is re-saturated to 16 bits.
  - One extra cycle of latency; the strobe moves to T+5.
  - Filter state clears with reset or with `enable_i` low.
- Not defined: the saturated CIC output goes directly to `pcm_data_o`. The filter logic is absent.

## Test plan
- Constant 1 on PDM, FIFO never full → first strobe at the 4th decimation window (3 discarded); `pcm_data_o` = 32767 (saturated from 32768); strobes every 1024 cycles.
- Constant 0 → `pcm_data_o` = −32768 on every strobe after warm-up.
- Alternating 1/0 per mic clock → `pcm_data_o` = 0 after warm-up; `mic_clk_o` period of 16 cycles with 8 cycles high.
- `fifo_full_i` high for 3 strobe slots → no `pcm_vld_o` in those slots; `overflow_o` = 1; `drop_cnt_o` = 3. Dropping `enable_i` clears both.
- Reset asserted mid-window → all outputs 0 immediately. After release, `mic_clk_o` restarts and the warm-up of 3 discarded samples repeats.
- With `PDM_DCBLOCK_EN`, constant 1 → first strobed value ≈ 32767 at T+5, then decays monotonically toward 0 (below 1000 after 1000 samples).
